bsa_ram_arbiter: RTL

//  Shares the single-port 32x8 BSA_RAM between two requesters: port 0 (host

---
 rtl/bsa_ram_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/bsa_ram_arbiter.sv
// bsa_ram_arbiter: shares the single-port BSA_RAM between the host loader (port 0)
// and the search engine (port 1) using ownership, round-robin and a bounded hold.
//
// state | meaning
// NONE  | no owner, RAM bus idle (address/data driven to zero)
// OWN0  | port 0 owns the RAM; gnt0 follows req0
// OWN1  | port 1 owns the RAM; gnt1 follows req1
module bsa_ram_arbiter #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 8,
    parameter int MAX_HOLD = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req0_i,
    input  logic              we0_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [DATA_W-1:0] wdata0_i,
    output logic              gnt0_o,
    output logic              rvalid0_o,
    input  logic              req1_i,
    input  logic              we1_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [DATA_W-1:0] wdata1_i,
    output logic              gnt1_o,
    output logic              rvalid1_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic [ADDR_W-1:0] ram_address_o,
    output logic [DATA_W-1:0] ram_data_o,
    output logic              ram_wren_o,
    input  logic [DATA_W-1:0] ram_q_i
);

    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        NONE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } owner_e;

    owner_e              owner_q, owner_d;
    logic                rr_next_q, rr_next_d;   // 0: port 0 wins next tie
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic                rvalid0_q, rvalid0_d;
    logic                rvalid1_q, rvalid1_d;
    logic                hold_last;
    logic                entering;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            owner_q    <= NONE;
            rr_next_q  <= 1'b0;
            hold_cnt_q <= '0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
        end else begin
            owner_q    <= owner_d;
            rr_next_q  <= rr_next_d;
            hold_cnt_q <= hold_cnt_d;
            rvalid0_q  <= rvalid0_d;
            rvalid1_q  <= rvalid1_d;
        end
    end

    assign hold_last = (hold_cnt_q == HOLD_LAST);

    always_comb begin
        owner_d = owner_q;
        case (owner_q)
            NONE: begin
                if (req0_i && req1_i) owner_d = rr_next_q ? OWN1 : OWN0;
                else if (req0_i)      owner_d = OWN0;
                else if (req1_i)      owner_d = OWN1;
            end
            OWN0: begin
                if (!req0_i)                owner_d = req1_i ? OWN1 : NONE;
                else if (req1_i && hold_last) owner_d = OWN1;
            end
            OWN1: begin
                if (!req1_i)                owner_d = req0_i ? OWN0 : NONE;
                else if (req0_i && hold_last) owner_d = OWN0;
            end
            default: owner_d = NONE;
        endcase
    end

    // Each new ownership hands the next tie to the other port and restarts the hold timer.
    always_comb begin
        entering   = (owner_d != owner_q) && (owner_d != NONE);
        rr_next_d  = rr_next_q;
        hold_cnt_d = hold_cnt_q;
        if (entering) begin
            rr_next_d  = (owner_d == OWN0);
            hold_cnt_d = '0;
        end else if ((gnt0_o || gnt1_o) && (owner_d == owner_q) && !hold_last) begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
        rvalid0_d = gnt0_o && !we0_i;
        rvalid1_d = gnt1_o && !we1_i;
    end

    always_comb begin
        gnt0_o        = (owner_q == OWN0) && req0_i;
        gnt1_o        = (owner_q == OWN1) && req1_i;
        ram_address_o = '0;
        ram_data_o    = '0;
        if (owner_q == OWN1) begin
            ram_address_o = addr1_i;
            ram_data_o    = wdata1_i;
        end else if (owner_q == OWN0) begin
            ram_address_o = addr0_i;
            ram_data_o    = wdata0_i;
        end
        ram_wren_o = rst_ni && ((gnt0_o && we0_i) || (gnt1_o && we1_i));
        rvalid0_o  = rvalid0_q;
        rvalid1_o  = rvalid1_q;
        rdata_o    = ram_q_i;
    end

endmodule
